// File: rtl/control_store_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_store_sequencer
//  Description : Microprogram sequencer: CSAR/MIR registers, 64-entry
//                writable control store, memory-wait stall and halt control.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_store_sequencer #(
    parameter int CW_WIDTH = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           NextControlStoreAddress,
    input  logic                 MemReady,
    input  logic                 Resume,
    input  logic                 ProgWrEn,
    input  logic [5:0]           ProgAddr,
    input  logic [CW_WIDTH-1:0]  ProgData,
    output logic [5:0]           SeqBranch,
    output logic [5:0]           DirectBranch,
    output logic [1:0]           NextSelType,
    output logic [CW_WIDTH-11:0] ControlSignals,
    output logic                 ControlValid,
    output logic [5:0]           CurrentAddress,
    output logic                 Halted,
    output logic                 WaitTimeout
);

    localparam logic [1:0] c_PRIME = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_HALT  = 2'd3;

    localparam int c_CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_WAIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [5:0]         c_ADDR0   = 6'd0;

    localparam int c_BIT_WAITMEM = 8;
    localparam int c_BIT_HALT    = 9;

    logic [1:0]          r_state;
    logic [5:0]          r_csar;
    logic [CW_WIDTH-1:0] r_mir;
    logic [c_CNT_W-1:0]  r_waitCnt;
    logic                r_waitTimeout;
    logic [CW_WIDTH-1:0] r_store [0:63];

    logic                w_valid;

    // Store has no reset; it is only written while halted and never on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_HALT) && ProgWrEn) begin
            r_store[ProgAddr] <= ProgData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_PRIME;
            r_csar        <= '0;
            r_mir         <= '0;
            r_waitCnt     <= '0;
            r_waitTimeout <= 1'b0;
        end else begin
            case (r_state)
                c_PRIME: begin
                    r_csar  <= c_ADDR0;
                    r_mir   <= r_store[c_ADDR0];
                    r_state <= c_RUN;
                end
                c_RUN: begin
                    if (r_mir[c_BIT_HALT]) begin
                        r_state <= c_HALT;
                    end else if (r_mir[c_BIT_WAITMEM] && !MemReady) begin
                        r_state   <= c_WAIT;
                        r_waitCnt <= c_CNT_ONE;
                    end else begin
                        // Read addressed by the live input so a new word issues every cycle.
                        r_csar <= NextControlStoreAddress;
                        r_mir  <= r_store[NextControlStoreAddress];
                    end
                end
                c_WAIT: begin
                    if (MemReady) begin
                        r_csar    <= NextControlStoreAddress;
                        r_mir     <= r_store[NextControlStoreAddress];
                        r_waitCnt <= '0;
                        r_state   <= c_RUN;
                    end else if (r_waitCnt == c_MAX_CNT) begin
                        r_waitTimeout <= 1'b1;
                        r_waitCnt     <= '0;
                        r_state       <= c_HALT;
                    end else begin
                        r_waitCnt <= r_waitCnt + c_CNT_ONE;
                    end
                end
                c_HALT: begin
                    if (Resume) begin
                        r_state       <= c_PRIME;
                        r_csar        <= c_ADDR0;
                        r_waitTimeout <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_PRIME;
                end
            endcase
        end
    end

    assign w_valid        = (r_state == c_RUN) || (r_state == c_WAIT);
    assign ControlValid   = w_valid;
    assign Halted         = (r_state == c_HALT);
    assign SeqBranch      = r_csar + 6'd1;
    assign CurrentAddress = r_csar;
    assign DirectBranch   = r_mir[5:0];
    assign NextSelType    = r_mir[7:6];
    assign ControlSignals = w_valid ? r_mir[CW_WIDTH-1:10] : '0;
    assign WaitTimeout    = r_waitTimeout;

endmodule
`default_nettype wire
